// File: rtl/imm_gen_pipe_pkg.sv
// Shared widths and immediate format codes for the immediate generator pipeline.
// XLEN is legal only at 32 or 64; SH-format legality depends on it.
package imm_gen_pipe_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMM_TYPE_W = 3;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6,
    IMM_SH   = 3'd7
  } imm_type_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode: instruction + format code -> XLEN immediate and illegal flag.
module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0]    instr,
  input  logic [IMM_TYPE_W-1:0] imm_type,
  output logic [XLEN-1:0]       imm_c,
  output logic                  illegal_c
);

  // Every format is first built as a 32-bit signed value, then widened by sign.
  logic signed [31:0] raw;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw       = '0;
    illegal_c = 1'b0;
    case (imm_type_e'(imm_type))
      IMM_I:  raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:  raw = {instr[31:12], 12'b0};
      IMM_J:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:  raw = {27'b0, instr[19:15]};
      IMM_SH: begin
        if (XLEN == 64) begin
          raw = {26'b0, instr[25:20]};
        end else begin
          raw       = {27'b0, instr[24:20]};
          illegal_c = instr[25];
        end
      end
      default: raw = '0;
    endcase
  end

  assign imm_c = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one-cycle pipeline with a 2-entry (main + skid) buffer
// and flush for mispredict recovery.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic [IMM_TYPE_W-1:0] in_imm_type,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_illegal
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;

  logic             m_valid, m_valid_d, k_valid, k_valid_d;
  logic [XLEN-1:0]  m_imm, m_imm_d, k_imm, k_imm_d;
  logic [TAG_W-1:0] m_tag, m_tag_d, k_tag, k_tag_d;
  logic             m_ill, m_ill_d, k_ill, k_ill_d;
  logic             accept, consume;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr     (in_instr),
    .imm_type  (in_imm_type),
    .imm_c     (dec_imm),
    .illegal_c (dec_illegal)
  );

  // Ready depends only on skid occupancy (and reset), never on out_ready.
  assign in_ready = !rst && !k_valid;
  assign accept   = in_valid && in_ready;
  assign consume  = m_valid && out_ready;

  always_comb begin
    m_valid_d = m_valid;
    m_imm_d   = m_imm;
    m_tag_d   = m_tag;
    m_ill_d   = m_ill;
    k_valid_d = k_valid;
    k_imm_d   = k_imm;
    k_tag_d   = k_tag;
    k_ill_d   = k_ill;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (consume && k_valid) begin
      m_valid_d = 1'b1;
      m_imm_d   = k_imm;
      m_tag_d   = k_tag;
      m_ill_d   = k_ill;
      k_valid_d = 1'b0;
    end else if (accept) begin
      if (!m_valid || consume) begin
        m_valid_d = 1'b1;
        m_imm_d   = dec_imm;
        m_tag_d   = in_tag;
        m_ill_d   = dec_illegal;
      end else begin
        k_valid_d = 1'b1;
        k_imm_d   = dec_imm;
        k_tag_d   = in_tag;
        k_ill_d   = dec_illegal;
      end
    end else if (consume) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_imm   <= '0;
      m_tag   <= '0;
      m_ill   <= 1'b0;
      k_valid <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
      k_ill   <= 1'b0;
    end else begin
      m_valid <= m_valid_d;
      m_imm   <= m_imm_d;
      m_tag   <= m_tag_d;
      m_ill   <= m_ill_d;
      k_valid <= k_valid_d;
      k_imm   <= k_imm_d;
      k_tag   <= k_tag_d;
      k_ill   <= k_ill_d;
    end
  end

  assign out_valid   = m_valid;
  assign out_imm     = m_imm;
  assign out_tag     = m_tag;
  assign out_illegal = m_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_type;
  logic [31:0] in_tag;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32),
    .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64),
    .out_illegal(ill64)
  );

  localparam logic [31:0] V_INSTR [10] = '{
    32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800000B7, 32'hFFDFF0EF,
    32'h000FD073, 32'h02105093, 32'hFFFFFFFF, 32'h12345037, 32'h01F05093};
  localparam logic [2:0]  V_TYPE [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4, 3'd7};
  localparam logic [31:0] V_E32 [10] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000, 32'hFFFFFFFC,
    32'h0000001F, 32'h00000001, 32'h00000000, 32'h12345000, 32'h0000001F};
  localparam logic [63:0] V_E64 [10] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
    64'hFFFFFFFFFFFFFFFC, 64'h000000000000001F, 64'h0000000000000021, 64'h0,
    64'h0000000012345000, 64'h000000000000001F};
  localparam logic        V_I32 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [2:0] t, input logic [31:0] tg);
    in_valid    = 1'b1;
    in_instr    = ins;
    in_imm_type = t;
    in_tag      = tg;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_imm_type = '0; in_tag = '0;
    tick();
    tick();
    total++; if (vld32 !== 1'b0) $display("FAIL reset_valid got %b want 0", vld32); else passed++;
    total++; if (imm32 !== 32'h0) $display("FAIL reset_imm32 got %h want 0", imm32); else passed++;
    total++; if (imm64 !== 64'h0) $display("FAIL reset_imm64 got %h want 0", imm64); else passed++;
    total++; if (tag32 !== 32'h0 || ill32 !== 1'b0) $display("FAIL reset_tag_ill got %h/%b want 0/0", tag32, ill32); else passed++;
    total++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0) $display("FAIL reset_ready got %b/%b want 0/0", rdy32, rdy64); else passed++;
    rst = 1'b0;
    #1;
    total++; if (rdy32 !== 1'b1) $display("FAIL post_reset_ready got %b want 1", rdy32); else passed++;
  endtask

  // Back-to-back format vectors; each result must appear exactly one cycle after its accept.
  task automatic test_formats;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(V_INSTR[i], V_TYPE[i], 32'h100 + i);
      tick();
      total++; if (vld32 !== 1'b1 || vld64 !== 1'b1) $display("FAIL fmt%0d_valid got %b/%b want 1/1", i, vld32, vld64); else passed++;
      total++; if (imm32 !== V_E32[i]) $display("FAIL fmt%0d_imm32 got %h want %h", i, imm32, V_E32[i]); else passed++;
      total++; if (imm64 !== V_E64[i]) $display("FAIL fmt%0d_imm64 got %h want %h", i, imm64, V_E64[i]); else passed++;
      total++; if (ill32 !== V_I32[i]) $display("FAIL fmt%0d_ill32 got %b want %b", i, ill32, V_I32[i]); else passed++;
      total++; if (ill64 !== 1'b0) $display("FAIL fmt%0d_ill64 got %b want 0", i, ill64); else passed++;
      total++; if (tag32 !== 32'h100 + i) $display("FAIL fmt%0d_tag got %h want %h", i, tag32, 32'h100 + i); else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++; if (vld32 !== 1'b0) $display("FAIL fmt_drain_valid got %b want 0", vld32); else passed++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(32'h00100093, 3'd1, 32'hA);
    tick();
    total++; if (rdy32 !== 1'b1 || tag32 !== 32'hA) $display("FAIL bp_a got rdy=%b tag=%h want 1/a", rdy32, tag32); else passed++;
    issue(32'h00200093, 3'd1, 32'hB);
    tick();
    total++; if (rdy32 !== 1'b0) $display("FAIL bp_full_ready got %b want 0", rdy32); else passed++;
    issue(32'h00300093, 3'd1, 32'hC);
    tick();
    total++; if (rdy32 !== 1'b0 || vld32 !== 1'b1) $display("FAIL bp_hold got rdy=%b vld=%b want 0/1", rdy32, vld32); else passed++;
    total++; if (tag32 !== 32'hA || imm32 !== 32'h1) $display("FAIL bp_stable got %h/%h want a/1", tag32, imm32); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (vld32 !== 1'b1 || tag32 !== 32'hB || imm32 !== 32'h2) $display("FAIL bp_out_b got %b/%h/%h want 1/b/2", vld32, tag32, imm32); else passed++;
    total++; if (rdy32 !== 1'b1) $display("FAIL bp_drain_ready got %b want 1", rdy32); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (vld32 !== 1'b1 || tag32 !== 32'hC || imm32 !== 32'h3) $display("FAIL bp_out_c got %b/%h/%h want 1/c/3", vld32, tag32, imm32); else passed++;
    tick();
    total++; if (vld32 !== 1'b0) $display("FAIL bp_end_valid got %b want 0", vld32); else passed++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    issue(32'h00400093, 3'd1, 32'hD);
    tick();
    issue(32'h00500093, 3'd1, 32'hE);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    total++; if (vld32 !== 1'b0) $display("FAIL flush_accept_valid got %b want 0", vld32); else passed++;
    total++; if (rdy32 !== 1'b1) $display("FAIL flush_accept_ready got %b want 1", rdy32); else passed++;
    issue(32'h00600093, 3'd1, 32'hF);
    tick();
    issue(32'h00700093, 3'd1, 32'h10);
    tick();
    total++; if (rdy32 !== 1'b0 || tag32 !== 32'hF) $display("FAIL flush_fill got rdy=%b tag=%h want 0/f", rdy32, tag32); else passed++;
    issue(32'h00800093, 3'd1, 32'h11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) $display("FAIL flush_full got vld=%b rdy=%b want 0/1", vld32, rdy32); else passed++;
    tick();
    total++; if (vld32 !== 1'b0) $display("FAIL flush_no_ghost got %b want 0", vld32); else passed++;
    issue(32'h05500093, 3'd1, 32'h55);
    tick();
    in_valid = 1'b0;
    total++; if (vld32 !== 1'b1 || tag32 !== 32'h55 || imm32 !== 32'h55) $display("FAIL flush_resume got %b/%h/%h want 1/55/55", vld32, tag32, imm32); else passed++;
    tick();
    total++; if (vld32 !== 1'b0) $display("FAIL flush_resume_once got %b want 0", vld32); else passed++;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    issue(32'h02105093, 3'd7, 32'h77);
    tick();
    issue(32'hFFF00093, 3'd1, 32'h78);
    tick();
    issue(32'h00900093, 3'd1, 32'h79);
    rst = 1'b1;
    #1;
    total++; if (rdy32 !== 1'b0) $display("FAIL rst_mid_ready_during got %b want 0", rdy32); else passed++;
    tick();
    total++; if (vld32 !== 1'b0 || imm32 !== 32'h0 || tag32 !== 32'h0 || ill32 !== 1'b0)
      $display("FAIL rst_mid_outputs got %b/%h/%h/%b want 0/0/0/0", vld32, imm32, tag32, ill32); else passed++;
    total++; if (imm64 !== 64'h0) $display("FAIL rst_mid_imm64 got %h want 0", imm64); else passed++;
    rst = 1'b0;
    out_ready = 1'b1;
    issue(32'h00A00093, 3'd1, 32'h99);
    #1;
    total++; if (rdy32 !== 1'b1) $display("FAIL rst_mid_ready_after got %b want 1", rdy32); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (vld32 !== 1'b1 || tag32 !== 32'h99 || imm32 !== 32'hA) $display("FAIL rst_mid_first got %b/%h/%h want 1/99/a", vld32, tag32, imm32); else passed++;
    tick();
    total++; if (vld32 !== 1'b0) $display("FAIL rst_mid_single got %b want 0", vld32); else passed++;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
